uvmt_logs_st_rst_seq: RTL and testbench



---
 rtl/uvmt_logs_st_rst_seq.sv | 130 +++++++++++++
 tb/tb_uvmt_logs_st_rst_seq.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uvmt_logs_st_rst_seq.sv
// Reset sequencer: synchronizes reset release, holds, then releases per-domain
// resets in staggered order; also provides a cycle timestamp and sequence count.
module uvmt_logs_st_rst_seq #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned NUM_DOMAINS = 3,
  parameter int unsigned STAGGER     = 4,
  parameter int unsigned TS_WIDTH    = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   sw_reset_req,
  output logic [NUM_DOMAINS-1:0] rst_n_out,
  output logic                   busy,
  output logic                   all_released,
  output logic [TS_WIDTH-1:0]    timestamp,
  output logic [7:0]             reset_count
);

  localparam int unsigned HCW = $clog2(HOLD_CYCLES) + 1;
  localparam int unsigned SCW = $clog2(STAGGER) + 1;
  localparam int unsigned IW  = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_HOLD,
    ST_RELEASE,
    ST_RUN
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   srst_n;
  logic [HCW-1:0]         hold_cnt;
  logic [SCW-1:0]         stag_cnt;
  logic [IW-1:0]          idx;
  logic                   hold_done;
  logic                   stag_done;
  logic                   last_idx;
  logic                   abort;
  logic                   enter_run;

  // Deassertion synchronizer; assertion is asynchronous through reset_n.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync <= '0;
    else          sync <= {sync[SYNC_STAGES-2:0], 1'b1};
  end

  assign srst_n = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    timestamp <= '0;
    else if (srst_n) timestamp <= timestamp + TS_WIDTH'(1);
  end

  always_comb begin
    hold_done = (hold_cnt == HCW'(HOLD_CYCLES - 1));
    stag_done = (stag_cnt == SCW'(STAGGER - 1));
    last_idx  = (idx == IW'(NUM_DOMAINS - 1));
    abort     = (state != ST_SYNC) && sw_reset_req;
    enter_run = !abort &&
                (((state == ST_HOLD) && hold_done && (NUM_DOMAINS == 1)) ||
                 ((state == ST_RELEASE) && stag_done && last_idx));
  end

  // Sequencer FSM. SYNC leaves on the edge where srst_n rises so that the hold
  // count starts from that edge, matching the software-request restart timing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_SYNC;
      hold_cnt     <= '0;
      stag_cnt     <= '0;
      idx          <= '0;
      rst_n_out    <= '0;
      all_released <= 1'b0;
      busy         <= 1'b1;
      reset_count  <= '0;
    end else begin
      if (abort) begin
        state     <= ST_HOLD;
        hold_cnt  <= '0;
        stag_cnt  <= '0;
        idx       <= '0;
        rst_n_out <= '0;
      end else begin
        unique case (state)
          ST_SYNC: begin
            if (sync[SYNC_STAGES-2]) begin
              state    <= ST_HOLD;
              hold_cnt <= '0;
            end
          end
          ST_HOLD: begin
            if (hold_done) begin
              rst_n_out <= NUM_DOMAINS'(1);
              stag_cnt  <= '0;
              idx       <= IW'(1);
              state     <= (NUM_DOMAINS == 1) ? ST_RUN : ST_RELEASE;
            end else begin
              hold_cnt <= hold_cnt + HCW'(1);
            end
          end
          ST_RELEASE: begin
            if (stag_done) begin
              rst_n_out <= rst_n_out | (NUM_DOMAINS'(1) << idx);
              stag_cnt  <= '0;
              if (last_idx) state <= ST_RUN;
              else          idx   <= idx + IW'(1);
            end else begin
              stag_cnt <= stag_cnt + SCW'(1);
            end
          end
          ST_RUN: begin
          end
        endcase
      end

      // Status flags follow entry to / exit from RUN.
      if (abort) begin
        all_released <= 1'b0;
        busy         <= 1'b1;
      end else if (enter_run) begin
        all_released <= 1'b1;
        busy         <= 1'b0;
        if (reset_count != 8'hFF) reset_count <= reset_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_uvmt_logs_st_rst_seq.sv
// Bench for uvmt_logs_st_rst_seq: default and minimal configurations checked
// every cycle against a time-based model, plus pinned scenario values.
module tb_uvmt_logs_st_rst_seq;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       sw_a = 1'b0;
  logic       sw_b = 1'b0;
  logic [2:0] rst_a;
  logic       busy_a, all_a;
  logic [31:0] ts_a;
  logic [7:0] cnt_a;
  logic [0:0] rst_b;
  logic       busy_b, all_b;
  logic [3:0] ts_b;
  logic [7:0] cnt_b;

  int errors = 0;
  int checks = 0;
  bit run_cmp = 1'b0;

  always #5 clk = ~clk;

  uvmt_logs_st_rst_seq u_dut_a (
    .clk(clk), .reset_n(reset_n), .sw_reset_req(sw_a), .rst_n_out(rst_a),
    .busy(busy_a), .all_released(all_a), .timestamp(ts_a), .reset_count(cnt_a)
  );

  uvmt_logs_st_rst_seq #(
    .SYNC_STAGES(2), .HOLD_CYCLES(1), .NUM_DOMAINS(1), .STAGGER(4), .TS_WIDTH(4)
  ) u_dut_b (
    .clk(clk), .reset_n(reset_n), .sw_reset_req(sw_b), .rst_n_out(rst_b),
    .busy(busy_b), .all_released(all_b), .timestamp(ts_b), .reset_count(cnt_b)
  );

  // Model: edges since reset release, edges since the current sequence started.
  int          m_s = 2;
  int          m_h [2] = '{16, 1};
  int          m_n [2] = '{3, 1};
  int          m_st [2] = '{4, 4};
  logic [31:0] m_mask [2] = '{32'hFFFF_FFFF, 32'h0000_000F};
  int          m_e = 0;
  int          m_since [2] = '{-1, -1};
  logic [31:0] m_ts [2] = '{32'd0, 32'd0};
  int          m_cnt [2] = '{0, 0};

  function automatic int last_rel(input int k);
    return m_h[k] + (m_n[k] - 1) * m_st[k];
  endfunction

  function automatic logic [7:0] exp_rst(input int k);
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < m_n[k]; i++)
      if (m_since[k] >= m_h[k] + i * m_st[k]) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic exp_all(input int k);
    return m_since[k] >= last_rel(k);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    int ns;
    bit req;
    if (!reset_n) begin
      m_e <= 0;
      for (int k = 0; k < 2; k++) begin
        m_since[k] <= -1;
        m_ts[k]    <= '0;
        m_cnt[k]   <= 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        req = (k == 0) ? sw_a : sw_b;
        ns  = m_since[k];
        if (m_e + 1 == m_s)  ns = 0;
        else if (m_e >= m_s) ns = req ? 0 : m_since[k] + 1;
        m_since[k] <= ns;
        if (m_e >= m_s) m_ts[k] <= (m_ts[k] + 32'd1) & m_mask[k];
        if (ns == last_rel(k) && m_cnt[k] < 255) m_cnt[k] <= m_cnt[k] + 1;
      end
      if (m_e < 1000000) m_e <= m_e + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t edge=%0d", name, act, exp, $time, m_e);
    end
  endtask

  // Per-cycle comparison against the model, away from the clock edge.
  always @(posedge clk) begin
    #2;
    if (run_cmp) begin
      check("a.rst_n_out",    64'(rst_a),  64'(exp_rst(0)));
      check("a.all_released", 64'(all_a),  64'(exp_all(0)));
      check("a.busy",         64'(busy_a), 64'(!exp_all(0)));
      check("a.timestamp",    64'(ts_a),   64'(m_ts[0]));
      check("a.reset_count",  64'(cnt_a),  64'(m_cnt[0]));
      check("b.rst_n_out",    64'(rst_b),  64'(exp_rst(1)));
      check("b.all_released", 64'(all_b),  64'(exp_all(1)));
      check("b.busy",         64'(busy_b), 64'(!exp_all(1)));
      check("b.timestamp",    64'(ts_b),   64'(m_ts[1] & 32'hF));
      check("b.reset_count",  64'(cnt_b),  64'(m_cnt[1]));
    end
  end

  task automatic wait_edge(input int n);
    int g;
    g = 0;
    while (m_e < n && g < 2000) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (m_e != n) begin
      errors++;
      $display("FAIL wait_edge: reached edge %0d wanted %0d", m_e, n);
    end
    #1;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset_n = 1'b0;
    repeat (cycles) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".rst_a"},  64'(rst_a),  64'd0);
    check({tag, ".busy_a"}, 64'(busy_a), 64'd1);
    check({tag, ".all_a"},  64'(all_a),  64'd0);
    check({tag, ".ts_a"},   64'(ts_a),   64'd0);
    check({tag, ".cnt_a"},  64'(cnt_a),  64'd0);
    check({tag, ".rst_b"},  64'(rst_b),  64'd0);
    check({tag, ".cnt_b"},  64'(cnt_b),  64'd0);
  endtask

  initial begin
    @(negedge clk);
    run_cmp = 1'b1;

    // Power-on with defaults; boundary instance runs alongside.
    repeat (4) @(negedge clk);
    #1;
    check_reset_vals("por");
    @(negedge clk);
    reset_n = 1'b1;
    wait_edge(2);
    check("b.rst@2", 64'(rst_b), 64'd0);
    wait_edge(3);
    check("b.rst@3", 64'(rst_b), 64'd1);
    check("b.cnt@3", 64'(cnt_b), 64'd1);
    wait_edge(17);
    check("a.rst@17", 64'(rst_a), 64'h0);
    check("b.ts@17",  64'(ts_b),  64'd15);
    wait_edge(18);
    check("a.rst@18", 64'(rst_a), 64'h1);
    check("b.ts@18",  64'(ts_b),  64'd0);
    wait_edge(22);
    check("a.rst@22", 64'(rst_a), 64'h3);
    wait_edge(26);
    check("a.rst@26", 64'(rst_a), 64'h7);
    check("a.all@26", 64'(all_a), 64'd1);
    check("a.cnt@26", 64'(cnt_a), 64'd1);
    check("a.ts@26",  64'(ts_a),  64'd24);

    // Software reset in RUN at edge 40.
    wait_edge(39);
    @(negedge clk);
    sw_a = 1'b1;
    wait_edge(40);
    check("a.rst@40",  64'(rst_a),  64'h0);
    check("a.busy@40", 64'(busy_a), 64'd1);
    @(negedge clk);
    sw_a = 1'b0;
    wait_edge(55);
    check("a.rst@55", 64'(rst_a), 64'h0);
    wait_edge(56);
    check("a.rst@56", 64'(rst_a), 64'h1);
    wait_edge(60);
    check("a.rst@60", 64'(rst_a), 64'h3);
    wait_edge(64);
    check("a.rst@64", 64'(rst_a), 64'h7);
    check("a.cnt@64", 64'(cnt_a), 64'd2);
    check("a.ts@64",  64'(ts_a),  64'd62);

    // Software reset during RELEASE at edge 20.
    do_reset(3);
    wait_edge(19);
    @(negedge clk);
    sw_a = 1'b1;
    wait_edge(20);
    check("rel.rst@20", 64'(rst_a), 64'h0);
    @(negedge clk);
    sw_a = 1'b0;
    wait_edge(26);
    check("rel.cnt@26", 64'(cnt_a), 64'd0);
    wait_edge(35);
    check("rel.rst@35", 64'(rst_a), 64'h0);
    wait_edge(36);
    check("rel.rst@36", 64'(rst_a), 64'h1);
    wait_edge(40);
    check("rel.rst@40", 64'(rst_a), 64'h3);
    wait_edge(44);
    check("rel.rst@44", 64'(rst_a), 64'h7);
    check("rel.cnt@44", 64'(cnt_a), 64'd1);
    check("rel.all@44", 64'(all_a), 64'd1);

    // Asynchronous abort between edges 19 and 20.
    do_reset(3);
    wait_edge(19);
    check("abort.rst@19", 64'(rst_a), 64'h1);
    reset_n = 1'b0;
    #1;
    check_reset_vals("abort");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    wait_edge(25);
    check("abort.rst@25", 64'(rst_a), 64'h3);
    wait_edge(26);
    check("abort.rst@26", 64'(rst_a), 64'h7);
    check("abort.cnt@26", 64'(cnt_a), 64'd1);

    // Randomized requests and asynchronous resets.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      sw_a = ($urandom_range(0, 15) == 0);
      sw_b = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 399) == 0) begin
        #($urandom_range(1, 4));
        reset_n = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        reset_n = 1'b1;
      end
    end
    @(negedge clk);
    sw_a = 1'b0;
    sw_b = 1'b0;

    // Saturation of reset_count on the minimal instance.
    do_reset(2);
    wait_edge(4);
    for (int p = 0; p < 260; p++) begin
      @(negedge clk);
      sw_b = 1'b1;
      @(negedge clk);
      sw_b = 1'b0;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    #1;
    check("sat.cnt_b", 64'(cnt_b), 64'd255);
    check("sat.all_b", 64'(all_b), 64'd1);
    check("sat.rst_b", 64'(rst_b), 64'd1);

    run_cmp = 1'b0;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
